f2f_tx_framer: RTL and testbench
================================

Name: f2f_tx_framer

Overview:
- Upstream framing stage for the 5-pin F2F LVDS serializer. It produces exactly one 32-bit word and one 2-bit command per clock.
- Takes payload words from a valid/ready stream, wraps each frame in 0x7E flag words and appends a CRC-32 word.
- Fills idle time with flags. On source underrun it inserts fill words; if the underrun is too long it aborts the frame.
- ser_din/ser_cmd connect directly to the serializer's din/serd_cmd.

Parameters:
- PRE_FLAGS, 2, flag words sent before first payload word (1..15)
- POST_FLAGS, 2, minimum flag words after CRC/abort before the next frame may start (1..15)
- MAX_WORDS, 256, maximum payload words per frame (2..65535)
- UNDERRUN_MAX, 4, consecutive fill cycles tolerated inside a frame before abort (1..15)
- CRC_EN, 1, append CRC word when 1

Ports:
- clk  in  1  single clock (serializer word clock)
- rst_n  in  1  asynchronous active-low reset
- tx_en  in  1  link enable; low = NOP output when idle
- s_data  in  32  payload word, byte [7:0] first
- s_valid  in  1  payload valid
- s_last  in  1  last word of frame
- s_ready  out  1  payload accepted when s_valid&s_ready
- ser_din  out  32  word to serializer
- ser_cmd  out  2  command to serializer
- busy  out  1  high in PRE/DATA/CRC/POST/DRAIN
- frame_done  out  1  one-cycle pulse when CRC word (or last word if CRC_EN=0) is issued
- frame_abort  out  1  one-cycle pulse on abort or truncation
- frame_cnt  out  16  completed frames, wraps at 0xFFFF->0

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; ser_din=0, ser_cmd=NOP, s_ready=0, busy=0, pulses=0, frame_cnt=0, CRC=0xFFFFFFFF.
  - Release is synchronous to clk; first active edge evaluates IDLE.
  - Reset mid-frame discards the frame silently (no abort pulse).
- ser_din, ser_cmd, busy and the pulses are registered (driven from the cycle's state decision). s_ready is combinational, = (state==DATA) & ~trunc_pending.
- Commands: NOP 00 (serializer holds), FLAG 01 (ser_din=0x7E7E7E7E), DATA 10, FILL 11 (ser_din=0).
- IDLE:
  - Outputs FLAG if tx_en, else NOP.
  - If tx_en & s_valid: go to PRE, load pre counter.
  - s_last on a word seen in IDLE is irrelevant; the word is not consumed.
- PRE: outputs FLAG for PRE_FLAGS cycles, then DATA. The CRC is initialised on entry.
- DATA:
  - On handshake: ser_cmd=DATA, ser_din=s_data, CRC updated, word count++, fill count cleared.
  - No handshake: ser_cmd=FILL, fill count++.
  - If fill count reaches UNDERRUN_MAX: output FLAG, pulse frame_abort, go to DRAIN.
  - s_last handshake: go to CRC (CRC_EN=1), else go to POST with frame_done.
  - When word count reaches MAX_WORDS without s_last, that word is treated as last: CRC is appended, frame_abort pulses together with frame_done, and the source's remaining words go through DRAIN after POST.
- CRC:
  - Outputs DATA with ser_din = CRC-32/MPEG-2 (poly 0x04C11DB7, init 0xFFFFFFFF, no reflection, no final XOR) over all payload words. Bytes enter in order [7:0],[15:8],[23:16],[31:24], each MSB first.
  - Pulses frame_done, frame_cnt++, then go to POST.
- POST:
  - Outputs FLAG for POST_FLAGS cycles regardless of tx_en.
  - Then goes to DRAIN if a drain is pending, else IDLE.
- DRAIN:
  - Outputs FLAG; s_ready=1; words are discarded with no CRC update.
  - Exits to POST (if entered by abort) or IDLE when s_valid&s_last.
- tx_en dropping mid-frame has no effect until IDLE.
- frame_cnt counts frame_done only. Aborted frames are not counted; truncated frames are counted.

Decomposition:
- Package f2f_tx_pkg: CMD_NOP/FLAG/DATA/FILL, FLAG_WORD=32'h7E7E7E7E, CRC_POLY, CRC_INIT, state encoding.
- Sub-module crc32_d32: combinational next-CRC from (crc_in[31:0], data[31:0]) with the byte order above. It is instantiated once; its register lives in the framer.

Test Plan:
- Reset defaults: rst_n=0 mid-DATA, then released → ser_cmd=00, s_ready=0, frame_cnt=0; with tx_en=1 and no s_valid, continuous ser_cmd=01, ser_din=0x7E7E7E7E.
- Basic frame: CRC_EN=0, PRE=2, POST=2; words 0x11223344 and 0xAABBCCDD (last) held valid from cycle k → cmds FLAG,FLAG at k+1,k+2; DATA 0x11223344 at k+3; DATA 0xAABBCCDD at k+4 with frame_done; FLAG,FLAG; then IDLE; frame_cnt=1.
- CRC: CRC_EN=1, single word 0x00000000 last → DATA 0x00000000 followed by DATA word equal to the bench CRC-32/MPEG-2 model of bytes 00 00 00 00; frame_done aligns with the CRC word.
- Underrun: UNDERRUN_MAX=4; one word, then s_valid=0 → four FILL cycles, then FLAG with frame_abort, then POST flags. The source then sends 3 words ending in s_last: all accepted and discarded; frame_cnt unchanged.
- Truncation: MAX_WORDS=4, 6-word frame → 4 DATA words then CRC with frame_done and frame_abort; words 5-6 drained; frame_cnt +1.
- Counter wrap and tx_en: preload 0xFFFF completions, one more frame → 0x0000. tx_en=0 while idle → NOP output, s_valid ignored, s_ready=0.

Source files
------------

// File: rtl/f2f_tx_pkg.sv
// Shared command codes, framing constants and FSM encoding for the F2F transmit framer.
package f2f_tx_pkg;

   typedef enum logic [1:0] {
      CMD_NOP  = 2'b00,
      CMD_FLAG = 2'b01,
      CMD_DATA = 2'b10,
      CMD_FILL = 2'b11
   } cmd_e;

   localparam logic [31:0] FLAG_WORD = 32'h7E7E7E7E;
   localparam logic [31:0] CRC_POLY  = 32'h04C11DB7;
   localparam logic [31:0] CRC_INIT  = 32'hFFFFFFFF;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRE   = 3'd1,
      ST_DATA  = 3'd2,
      ST_CRC   = 3'd3,
      ST_POST  = 3'd4,
      ST_DRAIN = 3'd5
   } state_e;

endpackage

// File: rtl/f2f_tx_framer_if.sv
// Payload stream into the framer: valid/ready words with an end-of-frame marker.
interface f2f_tx_framer_if;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_last;
   logic        s_ready;

   modport master (output s_data, output s_valid, output s_last, input  s_ready);
   modport slave  (input  s_data, input  s_valid, input  s_last, output s_ready);
endinterface

// File: rtl/f2f_tx_framer_crc32.sv
// One-word CRC-32/MPEG-2 step; byte [7:0] enters first, each byte MSB first.
module crc32_d32
   import f2f_tx_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [31:0] data,
   output logic [31:0] crc_out
);
   always_comb begin
      logic [31:0] c;
      logic        fb;
      c  = crc_in;
      fb = 1'b0;
      for (int b = 0; b < 4; b++) begin
         for (int i = 7; i >= 0; i--) begin
            fb = c[31] ^ data[8*b + i];
            c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
         end
      end
      crc_out = c;
   end
endmodule

// File: rtl/f2f_tx_framer.sv
// F2F transmit framer: wraps payload in 0x7E flags, appends CRC-32, fills underruns
// and aborts on long stalls. Emits one word plus command to the serializer every clock.
//
// state | meaning
// IDLE  | link idle, FLAG (tx_en) or NOP; frame starts on s_valid
// PRE   | leading flags before the first payload word
// DATA  | payload words, FILL on underrun
// CRC   | CRC word, frame complete
// POST  | trailing flags, minimum inter-frame gap
// DRAIN | discard source words up to s_last
module f2f_tx_framer
   import f2f_tx_pkg::*;
#(
   parameter int PRE_FLAGS    = 2,
   parameter int POST_FLAGS   = 2,
   parameter int MAX_WORDS    = 256,
   parameter int UNDERRUN_MAX = 4,
   parameter int CRC_EN       = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           tx_en,
   f2f_tx_framer_if.slave s_if,
   output logic [31:0]    ser_din,
   output logic [1:0]     ser_cmd,
   output logic           busy,
   output logic           frame_done,
   output logic           frame_abort,
   output logic [15:0]    frame_cnt
);
   state_e      state, state_nx;
   logic [3:0]  pre_cnt, pre_nx;
   logic [3:0]  post_cnt, post_nx;
   logic [3:0]  fill_left, fill_nx;
   logic [15:0] words_left, words_nx;
   logic [15:0] frame_cnt_r;
   logic [31:0] crc_r, crc_nx, crc_calc, din_nx;
   logic        trunc_pending, trunc_nx;
   logic        done_nx, abort_nx, cnt_inc, hs;
   cmd_e        cmd_nx;

   crc32_d32 u_crc32 (.crc_in(crc_r), .data(s_if.s_data), .crc_out(crc_calc));

   assign s_if.s_ready = ((state == ST_DATA) && !trunc_pending) || (state == ST_DRAIN);
   assign hs           = s_if.s_valid && s_if.s_ready;
   assign frame_cnt    = frame_cnt_r;

   always_comb begin
      state_nx = state;
      pre_nx   = pre_cnt;
      post_nx  = post_cnt;
      fill_nx  = fill_left;
      words_nx = words_left;
      crc_nx   = crc_r;
      trunc_nx = trunc_pending;
      din_nx   = 32'h0;
      cmd_nx   = CMD_NOP;
      done_nx  = 1'b0;
      abort_nx = 1'b0;
      cnt_inc  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (tx_en) begin
               cmd_nx = CMD_FLAG;
               din_nx = FLAG_WORD;
               if (s_if.s_valid) begin
                  state_nx = ST_PRE;
                  pre_nx   = 4'(PRE_FLAGS - 1);
                  crc_nx   = CRC_INIT;
                  words_nx = 16'(MAX_WORDS - 1);
                  fill_nx  = 4'(UNDERRUN_MAX);
                  trunc_nx = 1'b0;
               end
            end
         end
         ST_PRE: begin
            cmd_nx = CMD_FLAG;
            din_nx = FLAG_WORD;
            if (pre_cnt == 4'd0) state_nx = ST_DATA;
            else                 pre_nx   = pre_cnt - 4'd1;
         end
         ST_DATA: begin
            if (hs) begin
               cmd_nx   = CMD_DATA;
               din_nx   = s_if.s_data;
               crc_nx   = crc_calc;
               fill_nx  = 4'(UNDERRUN_MAX);
               words_nx = words_left - 16'd1;
               // Hitting the word limit closes the frame as if s_last had been seen.
               if (s_if.s_last || (words_left == 16'd0)) begin
                  trunc_nx = !s_if.s_last;
                  if (CRC_EN != 0) begin
                     state_nx = ST_CRC;
                  end else begin
                     done_nx  = 1'b1;
                     abort_nx = !s_if.s_last;
                     cnt_inc  = 1'b1;
                     state_nx = ST_POST;
                     post_nx  = 4'(POST_FLAGS - 1);
                  end
               end
            end else if (fill_left == 4'd0) begin
               cmd_nx   = CMD_FLAG;
               din_nx   = FLAG_WORD;
               abort_nx = 1'b1;
               state_nx = ST_DRAIN;
            end else begin
               cmd_nx  = CMD_FILL;
               fill_nx = fill_left - 4'd1;
            end
         end
         ST_CRC: begin
            cmd_nx   = CMD_DATA;
            din_nx   = crc_r;
            done_nx  = 1'b1;
            abort_nx = trunc_pending;
            cnt_inc  = 1'b1;
            state_nx = ST_POST;
            post_nx  = 4'(POST_FLAGS - 1);
         end
         ST_POST: begin
            cmd_nx = CMD_FLAG;
            din_nx = FLAG_WORD;
            if (post_cnt == 4'd0) state_nx = trunc_pending ? ST_DRAIN : ST_IDLE;
            else                  post_nx  = post_cnt - 4'd1;
         end
         ST_DRAIN: begin
            cmd_nx = CMD_FLAG;
            din_nx = FLAG_WORD;
            // A truncation drain already had its POST; an abort drain still owes one.
            if (s_if.s_valid && s_if.s_last) begin
               if (trunc_pending) begin
                  state_nx = ST_IDLE;
                  trunc_nx = 1'b0;
               end else begin
                  state_nx = ST_POST;
                  post_nx  = 4'(POST_FLAGS - 1);
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         pre_cnt       <= 4'd0;
         post_cnt      <= 4'd0;
         fill_left     <= 4'd0;
         words_left    <= 16'd0;
         crc_r         <= CRC_INIT;
         trunc_pending <= 1'b0;
         ser_din       <= 32'h0;
         ser_cmd       <= CMD_NOP;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
         frame_abort   <= 1'b0;
         frame_cnt_r   <= 16'd0;
      end else begin
         state         <= state_nx;
         pre_cnt       <= pre_nx;
         post_cnt      <= post_nx;
         fill_left     <= fill_nx;
         words_left    <= words_nx;
         crc_r         <= crc_nx;
         trunc_pending <= trunc_nx;
         ser_din       <= din_nx;
         ser_cmd       <= cmd_nx;
         busy          <= (state_nx != ST_IDLE);
         frame_done    <= done_nx;
         frame_abort   <= abort_nx;
         if (cnt_inc) frame_cnt_r <= frame_cnt_r + 16'd1;
      end
   end
endmodule

// File: tb/tb_f2f_tx_framer.sv
// Scoreboard bench for f2f_tx_framer: two instances (no-CRC / CRC with 4-word limit)
// share one source; a monitor pops expected words and abort events as they appear.
module tb_f2f_tx_framer;
   localparam int          UMAX  = 4;
   localparam logic [31:0] FLAGW = 32'h7E7E7E7E;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic tx_en = 1'b0;
   logic sel = 1'b0;
   logic [31:0] src_data = 32'h0;
   logic src_valid = 1'b0;
   logic src_last = 1'b0;
   logic src_ready;

   always #5 clk = ~clk;

   f2f_tx_framer_if if0 ();
   f2f_tx_framer_if if1 ();
   assign if0.s_data  = src_data;
   assign if0.s_last  = src_last;
   assign if0.s_valid = src_valid & ~sel;
   assign if1.s_data  = src_data;
   assign if1.s_last  = src_last;
   assign if1.s_valid = src_valid & sel;

   logic [31:0] din0, din1, ser_din;
   logic [1:0]  cmd0, cmd1, ser_cmd;
   logic        busy0, busy1, busy, done0, done1, fdone, abrt0, abrt1, fabort;
   logic [15:0] cnt0, cnt1, fcnt;

   f2f_tx_framer #(.PRE_FLAGS(2), .POST_FLAGS(2), .MAX_WORDS(256), .UNDERRUN_MAX(UMAX), .CRC_EN(0)) u_nocrc (
      .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .s_if(if0.slave),
      .ser_din(din0), .ser_cmd(cmd0), .busy(busy0), .frame_done(done0),
      .frame_abort(abrt0), .frame_cnt(cnt0));

   f2f_tx_framer #(.PRE_FLAGS(2), .POST_FLAGS(2), .MAX_WORDS(4), .UNDERRUN_MAX(UMAX), .CRC_EN(1)) u_crc (
      .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .s_if(if1.slave),
      .ser_din(din1), .ser_cmd(cmd1), .busy(busy1), .frame_done(done1),
      .frame_abort(abrt1), .frame_cnt(cnt1));

   assign src_ready = sel ? if1.s_ready : if0.s_ready;
   assign ser_din   = sel ? din1  : din0;
   assign ser_cmd   = sel ? cmd1  : cmd0;
   assign busy      = sel ? busy1 : busy0;
   assign fdone     = sel ? done1 : done0;
   assign fabort    = sel ? abrt1 : abrt0;
   assign fcnt      = sel ? cnt1  : cnt0;

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   // Reference CRC-32/MPEG-2, byte at a time.
   function automatic logic [31:0] crc_word(input logic [31:0] c_in, input logic [31:0] w);
      logic [31:0] c;
      c = c_in;
      for (int b = 0; b < 4; b++) begin
         c = c ^ {w[8*b +: 8], 24'h0};
         for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
      end
      return c;
   endfunction

   typedef struct {
      bit          is_abort;
      logic [31:0] data;
      bit          done;
      bit          abort;
      logic [15:0] cnt;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [15:0] exp_cnt [2];
   logic [31:0] frm[$];
   int          fill_run = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         fill_run = 0;
      end else begin
         case (ser_cmd)
            2'b10: begin
               check("sb_has_word", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  mon_e = exp_q.pop_front();
                  check("sb_item_is_word", 32'(mon_e.is_abort), 0);
                  check("data_word", ser_din, mon_e.data);
                  check("done_pulse", 32'(fdone), 32'(mon_e.done));
                  check("abort_pulse", 32'(fabort), 32'(mon_e.abort));
                  if (mon_e.done) check("frame_cnt", 32'(fcnt), 32'(mon_e.cnt));
               end
               fill_run = 0;
            end
            2'b11: begin
               check("fill_word", ser_din, 0);
               check("fill_no_pulse", 32'({fdone, fabort}), 0);
               fill_run++;
            end
            2'b01: begin
               check("flag_word", ser_din, FLAGW);
               check("flag_no_done", 32'(fdone), 0);
               if (fabort) begin
                  check("sb_has_abort", 32'(exp_q.size() != 0), 1);
                  if (exp_q.size() != 0) begin
                     mon_e = exp_q.pop_front();
                     check("sb_item_is_abort", 32'(mon_e.is_abort), 1);
                     check("fills_before_abort", 32'(fill_run), UMAX);
                  end
               end
               fill_run = 0;
            end
            default: check("nop_no_pulse", 32'({fdone, fabort}), 0);
         endcase
      end
   end

   task automatic send_word(input logic [31:0] d, input bit last, input int gap);
      int t;
      src_valid = 1'b0;
      repeat (gap) @(negedge clk);
      src_valid = 1'b1;
      src_data  = d;
      src_last  = last;
      t = 0;
      while (!src_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("handshake_timeout", 32'(src_ready), 1);
      @(negedge clk);
      src_valid = 1'b0;
      src_last  = 1'b0;
   endtask

   // Expected output of a frame from the framing rules alone, then drive it.
   task automatic send_frame(input int gap_max);
      int          n, mx, emit;
      bit          crc_en, trunc;
      logic [31:0] crc;
      exp_t        e;
      n      = frm.size();
      crc_en = sel;
      mx     = sel ? 4 : 256;
      emit   = (n < mx) ? n : mx;
      trunc  = (n > mx);
      crc    = 32'hFFFFFFFF;
      for (int i = 0; i < emit; i++) begin
         crc        = crc_word(crc, frm[i]);
         e.is_abort = 1'b0;
         e.data     = frm[i];
         e.done     = (i == emit - 1) && !crc_en;
         e.abort    = e.done && trunc;
         if (e.done) exp_cnt[sel] = exp_cnt[sel] + 16'd1;
         e.cnt      = exp_cnt[sel];
         exp_q.push_back(e);
      end
      if (crc_en) begin
         exp_cnt[sel] = exp_cnt[sel] + 16'd1;
         e = '{1'b0, crc, 1'b1, trunc, exp_cnt[sel]};
         exp_q.push_back(e);
      end
      for (int i = 0; i < n; i++) send_word(frm[i], (i == n - 1), int'($urandom_range(gap_max, 0)));
   endtask

   task automatic wait_sb(input string name);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      check(name, 32'(exp_q.size()), 0);
   endtask

   logic [1:0] bas_cmd  [8] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01};
   logic       bas_busy [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

   initial begin
      exp_t e;
      exp_cnt[0] = 16'd0;
      exp_cnt[1] = 16'd0;
      rst_n = 1'b0;
      tx_en = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_cmd", 32'(ser_cmd), 0);
      check("rst_din", ser_din, 0);
      check("rst_ready", 32'(src_ready), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_cnt", 32'(fcnt), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_flag_cmd", 32'(ser_cmd), 1);
      check("idle_flag_din", ser_din, FLAGW);

      // basic two-word frame, cycle-exact command sequence
      frm = '{32'h11223344, 32'hAABBCCDD};
      fork
         send_frame(0);
         begin
            for (int i = 0; i < 8; i++) begin
               @(negedge clk);
               check("basic_cmd", 32'(ser_cmd), 32'(bas_cmd[i]));
               check("basic_busy", 32'(busy), 32'(bas_busy[i]));
            end
         end
      join
      wait_sb("basic_sb_drained");
      check("basic_cnt", 32'(fcnt), 1);

      // reset in the middle of DATA
      e = '{1'b0, 32'h5A5A0001, 1'b0, 1'b0, 16'd0};
      exp_q.push_back(e);
      send_word(32'h5A5A0001, 1'b0, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid_cmd", 32'(ser_cmd), 0);
      check("rst_mid_ready", 32'(src_ready), 0);
      check("rst_mid_cnt", 32'(fcnt), 0);
      check("rst_mid_abort", 32'(fabort), 0);
      check("rst_mid_busy", 32'(busy), 0);
      check("rst_mid_sb", 32'(exp_q.size()), 0);
      exp_q.delete();
      exp_cnt[0] = 16'd0;
      exp_cnt[1] = 16'd0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // tx_en low while idle: NOP and source ignored
      tx_en     = 1'b0;
      src_valid = 1'b1;
      src_data  = 32'hCAFEF00D;
      repeat (4) begin
         @(negedge clk);
         check("txoff_cmd", 32'(ser_cmd), 0);
         check("txoff_ready", 32'(src_ready), 0);
         check("txoff_busy", 32'(busy), 0);
      end
      src_valid = 1'b0;
      tx_en     = 1'b1;
      repeat (2) @(negedge clk);

      // CRC of a single zero word
      sel = 1'b1;
      @(negedge clk);
      frm = '{32'h00000000};
      send_frame(0);
      wait_sb("crc0_sb_drained");

      // underrun abort, then the source finishes the frame into DRAIN
      sel = 1'b0;
      repeat (2) @(negedge clk);
      e = '{1'b0, 32'h0BADBEEF, 1'b0, 1'b0, 16'd0};
      exp_q.push_back(e);
      e = '{1'b1, 32'h0, 1'b0, 1'b1, 16'd0};
      exp_q.push_back(e);
      send_word(32'h0BADBEEF, 1'b0, 0);
      wait_sb("underrun_abort_seen");
      send_word(32'h00000001, 1'b0, 0);
      send_word(32'h00000002, 1'b0, 0);
      send_word(32'h00000003, 1'b1, 0);
      repeat (5) @(negedge clk);
      check("underrun_cnt", 32'(fcnt), 32'(exp_cnt[0]));
      check("underrun_idle", 32'(busy), 0);

      // truncation: 6-word frame into a 4-word limit
      sel = 1'b1;
      repeat (2) @(negedge clk);
      frm.delete();
      for (int i = 0; i < 6; i++) frm.push_back($urandom());
      send_frame(0);
      wait_sb("trunc_sb_drained");
      repeat (4) @(negedge clk);
      check("trunc_cnt", 32'(fcnt), 32'(exp_cnt[1]));
      check("trunc_idle", 32'(busy), 0);

      // random frames with underrun gaps up to the tolerated limit
      for (int r = 0; r < 12; r++) begin
         sel = r[0];
         repeat (2) @(negedge clk);
         frm.delete();
         for (int i = 0; i < int'($urandom_range(6, 1)); i++) frm.push_back($urandom());
         send_frame(UMAX);
         wait_sb("rand_sb_drained");
         repeat (4) @(negedge clk);
      end

      // frame counter wrap
      sel = 1'b1;
      repeat (2) @(negedge clk);
      force u_crc.frame_cnt_r = 16'hFFFF;
      @(negedge clk);
      release u_crc.frame_cnt_r;
      exp_cnt[1] = 16'hFFFF;
      frm = '{32'h01020304, 32'h05060708};
      send_frame(1);
      wait_sb("wrap_sb_drained");
      check("wrap_cnt", 32'(fcnt), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
      $fatal(1);
   end
endmodule
